// File: rtl/fe_pattern_match_pkg.sv
// Shared types for the front-end pattern-match trigger.
package fe_pattern_match_pkg;
  localparam int PM_BYTE_W = 8;

  typedef enum logic [2:0] {
    PM_IDLE    = 3'd0,
    PM_ARMED   = 3'd1,
    PM_DELAY   = 3'd2,
    PM_CAPTURE = 3'd3,
    PM_DONE    = 3'd4
  } pm_state_e;
endpackage

// File: rtl/fe_pm_compare.sv
// Byte history shift register plus masked compare of the newest L bytes.
module fe_pm_compare
  import fe_pattern_match_pkg::*;
#(
  parameter int pBYTES = 8,
  parameter int LEN_W  = $clog2(pBYTES) + 1
) (
  input  logic                          fe_clk,
  input  logic                          reset_i,
  input  logic                          clr_seen,
  input  logic                          pm_wr,
  input  logic                          rxactive,
  input  logic [PM_BYTE_W-1:0]          pm_data,
  input  logic [PM_BYTE_W*pBYTES-1:0]   pattern,
  input  logic [PM_BYTE_W*pBYTES-1:0]   mask,
  input  logic [LEN_W-1:0]              match_len,
  output logic                          hit
);
  logic [PM_BYTE_W*pBYTES-1:0] sr, sr_next;
  logic [LEN_W-1:0]            seen, seen_base, seen_next, len_eff;
  logic [pBYTES-1:0]           byte_ok;

  assign sr_next = {sr[PM_BYTE_W*pBYTES-PM_BYTE_W-1:0], pm_data};

  // Dropping rxactive forgets history so a match never spans two packets.
  always_comb begin
    seen_base = clr_seen ? '0 : seen;
    seen_next = seen_base;
    if (pm_wr)
      seen_next = (seen_base >= LEN_W'(pBYTES)) ? LEN_W'(pBYTES) : seen_base + LEN_W'(1);
    else if (!rxactive)
      seen_next = '0;
  end

  always_comb begin
    len_eff = match_len;
    if (match_len == '0)                len_eff = LEN_W'(1);
    else if (match_len > LEN_W'(pBYTES)) len_eff = LEN_W'(pBYTES);
  end

  for (genvar i = 0; i < pBYTES; i++) begin : g_byte
    assign byte_ok[i] = (LEN_W'(i) >= len_eff) ||
      (((sr_next[PM_BYTE_W*i +: PM_BYTE_W] ^ pattern[PM_BYTE_W*i +: PM_BYTE_W]) &
        mask[PM_BYTE_W*i +: PM_BYTE_W]) == '0);
  end

  assign hit = pm_wr && (seen_next >= len_eff) && (&byte_ok);

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      sr   <= '0;
      seen <= '0;
    end else begin
      if (pm_wr) sr <= sr_next;
      seen <= seen_next;
    end
  end
endmodule

// File: rtl/fe_pattern_match.sv
// Armed pattern trigger: masked byte match, optional delay, then holds capture enable.
module fe_pattern_match
  import fe_pattern_match_pkg::*;
#(
  parameter int pBYTES = 8,
  parameter int pDLY_W = 16
) (
  input  logic                        fe_clk,
  input  logic                        reset_i,
  input  logic                        I_arm,
  input  logic [8*pBYTES-1:0]         I_pattern,
  input  logic [8*pBYTES-1:0]         I_mask,
  input  logic [$clog2(pBYTES):0]     I_match_len,
  input  logic [pDLY_W-1:0]           I_delay,
  input  logic [7:0]                  I_pm_data,
  input  logic                        I_pm_wr,
  input  logic                        I_rxactive,
  input  logic                        I_capturing,
  output logic                        O_capture_enable,
  output logic                        O_match,
  output logic                        O_armed,
  output logic [2:0]                  O_state
);
  localparam int LEN_W = $clog2(pBYTES) + 1;

  pm_state_e         state, state_n;
  logic              arm_r, arm_rise, hit, armed_hit, seen_cap, match_r;
  logic [pDLY_W-1:0] dly_cnt;

  assign arm_rise  = I_arm & ~arm_r;
  assign armed_hit = (state == PM_ARMED) && I_arm && hit;

  fe_pm_compare #(.pBYTES(pBYTES), .LEN_W(LEN_W)) u_cmp (
    .fe_clk    (fe_clk),
    .reset_i   (reset_i),
    .clr_seen  (arm_rise && (state == PM_IDLE || state == PM_DONE)),
    .pm_wr     (I_pm_wr),
    .rxactive  (I_rxactive),
    .pm_data   (I_pm_data),
    .pattern   (I_pattern),
    .mask      (I_mask),
    .match_len (I_match_len),
    .hit       (hit)
  );

  always_comb begin
    state_n = state;
    if (!I_arm) state_n = PM_IDLE;
    else begin
      case (state)
        PM_IDLE, PM_DONE: if (arm_rise) state_n = PM_ARMED;
        PM_ARMED:         if (hit) state_n = (I_delay == '0) ? PM_CAPTURE : PM_DELAY;
        PM_DELAY:         if (dly_cnt == pDLY_W'(1)) state_n = PM_CAPTURE;
        PM_CAPTURE:       if (seen_cap && !I_capturing) state_n = PM_DONE;
        default:          state_n = PM_IDLE;
      endcase
    end
  end

  // arm_r resets high so a level held through reset is not taken as a new arm edge.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state    <= PM_IDLE;
      arm_r    <= 1'b1;
      dly_cnt  <= '0;
      seen_cap <= 1'b0;
      match_r  <= 1'b0;
    end else begin
      state   <= state_n;
      arm_r   <= I_arm;
      match_r <= armed_hit;
      if (armed_hit)              dly_cnt <= I_delay;
      else if (state == PM_DELAY) dly_cnt <= dly_cnt - 1'b1;
      if (state != PM_CAPTURE)    seen_cap <= 1'b0;
      else if (I_capturing)       seen_cap <= 1'b1;
    end
  end

  assign O_capture_enable = (state == PM_CAPTURE);
  assign O_armed          = (state == PM_ARMED) || (state == PM_DELAY) || (state == PM_CAPTURE);
  assign O_state          = state;
  assign O_match          = match_r;
endmodule

// File: tb/tb_fe_pattern_match.sv
// Directed bench for fe_pattern_match with hand-computed expectations.
module tb_fe_pattern_match;
  localparam int pBYTES = 8;
  localparam int pDLY_W = 16;

  logic                  fe_clk = 1'b0;
  logic                  reset_i;
  logic                  I_arm;
  logic [8*pBYTES-1:0]   I_pattern, I_mask;
  logic [3:0]            I_match_len;
  logic [pDLY_W-1:0]     I_delay;
  logic [7:0]            I_pm_data;
  logic                  I_pm_wr, I_rxactive, I_capturing;
  logic                  O_capture_enable, O_match, O_armed;
  logic [2:0]            O_state;

  int n_checks = 0;
  int n_errors = 0;

  fe_pattern_match #(.pBYTES(pBYTES), .pDLY_W(pDLY_W)) dut (
    .fe_clk(fe_clk), .reset_i(reset_i), .I_arm(I_arm),
    .I_pattern(I_pattern), .I_mask(I_mask), .I_match_len(I_match_len),
    .I_delay(I_delay), .I_pm_data(I_pm_data), .I_pm_wr(I_pm_wr),
    .I_rxactive(I_rxactive), .I_capturing(I_capturing),
    .O_capture_enable(O_capture_enable), .O_match(O_match),
    .O_armed(O_armed), .O_state(O_state)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    I_pm_data = b;
    I_pm_wr   = 1'b1;
    tick();
    I_pm_wr   = 1'b0;
  endtask

  task automatic rearm();
    I_arm = 1'b0; tick();
    I_arm = 1'b1; tick();
  endtask

  initial begin
    logic [7:0] pat8 [8];
    logic [7:0] rb;
    reset_i = 1'b1; I_arm = 1'b0; I_pattern = '0; I_mask = '1; I_match_len = 4'd2;
    I_delay = '0; I_pm_data = '0; I_pm_wr = 1'b0; I_rxactive = 1'b1; I_capturing = 1'b0;
    repeat (3) tick();
    chk("rst_state", O_state, 0);
    chk("rst_en", O_capture_enable, 0);
    chk("rst_match", O_match, 0);
    chk("rst_armed", O_armed, 0);
    reset_i = 1'b0;
    tick();

    // Basic match, no delay: newest byte 2D in byte 0, A5 in byte 1
    I_pattern = 64'h0000_0000_0000_A52D;
    I_arm = 1'b1; tick();
    chk("arm_state", O_state, 1);
    chk("arm_armed", O_armed, 1);
    send(8'hA5);
    chk("m1_first", O_match, 0);
    send(8'h2D);
    chk("m1_match", O_match, 1);
    chk("m1_en", O_capture_enable, 1);
    chk("m1_state", O_state, 3);
    tick();
    chk("m1_pulse", O_match, 0);

    // Capture runs 10 cycles then ends
    I_capturing = 1'b1;
    repeat (10) tick();
    chk("cap_hold", O_capture_enable, 1);
    I_capturing = 1'b0;
    tick();
    chk("done_state", O_state, 4);
    chk("done_en", O_capture_enable, 0);
    chk("done_armed", O_armed, 0);
    send(8'hA5); send(8'h2D);
    chk("done_nomatch", O_match, 0);
    chk("done_stay", O_state, 4);
    rearm();
    chk("rearm_state", O_state, 1);

    // Delay of 5: enable rises 5 edges after the match edge
    I_delay = 16'd5;
    send(8'hA5); send(8'h2D);
    chk("d_match", O_match, 1);
    chk("d_state", O_state, 2);
    chk("d_en0", O_capture_enable, 0);
    send(8'hA5);
    send(8'h2D);
    chk("d_rehit", O_match, 0);
    tick();
    tick();
    chk("d_en4", O_capture_enable, 0);
    tick();
    chk("d_en5", O_capture_enable, 1);
    chk("d_cap", O_state, 3);
    I_arm = 1'b0; tick();
    chk("drop_cap_en", O_capture_enable, 0);
    chk("drop_cap_st", O_state, 0);

    // Packet split prevents a match; masked byte 1 matches anything
    I_delay = '0;
    I_arm = 1'b1; tick();
    send(8'hA5);
    I_rxactive = 1'b0; repeat (3) tick(); I_rxactive = 1'b1;
    send(8'h2D);
    chk("split_nomatch", O_match, 0);
    chk("split_state", O_state, 1);
    I_mask = 64'hFFFF_FFFF_FFFF_00FF;
    send(8'h77);
    chk("mask_first", O_match, 0);
    send(8'h2D);
    chk("mask_match", O_match, 1);
    I_mask = '1;

    // Drop arm while delaying
    I_arm = 1'b0; tick();
    I_delay = 16'd5;
    I_arm = 1'b1; tick();
    send(8'hA5); send(8'h2D);
    chk("dly2_state", O_state, 2);
    I_arm = 1'b0; tick();
    chk("drop_dly_st", O_state, 0);
    chk("drop_dly_en", O_capture_enable, 0);

    // Reset while armed, arm held high: needs a low before re-arming
    I_delay = '0;
    I_arm = 1'b1; tick();
    chk("pre_rst", O_state, 1);
    reset_i = 1'b1; tick();
    chk("mid_rst_st", O_state, 0);
    chk("mid_rst_armed", O_armed, 0);
    reset_i = 1'b0; tick(); tick();
    chk("post_rst_idle", O_state, 0);
    rearm();
    chk("post_rst_arm", O_state, 1);

    // Full-length match after random prefix (prefix bytes < 0x80 cannot end a false match)
    I_match_len = 4'd8;
    I_pattern = 64'h0123_4567_89AB_CDEF;
    pat8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 127));
      send(rb);
      chk("l8_rand", O_match, 0);
    end
    for (int i = 0; i < 8; i++) begin
      send(pat8[i]);
      chk("l8_pat", O_match, (i == 7) ? 1 : 0);
    end

    // L=0 and L=1 both compare only the newest byte
    I_pattern = 64'h0000_0000_0000_115A;
    for (int l = 0; l < 2; l++) begin
      I_match_len = 4'(l);
      rearm();
      send(8'h11);
      chk("l01_miss", O_match, 0);
      send(8'h5A);
      chk("l01_hit", O_match, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
